elixirchip_es1_spu_op_arbiter: RTL and testbench

ELIXIRCHIP_ES1_SPU_OP_ARBITER -- requirements
Module: elixirchip_es1_spu_op_arbiter

---
 rtl/elixirchip_es1_spu_op_arbiter.sv | 75 +++++++
 tb/tb_elixirchip_es1_spu_op_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// elixirchip_es1_spu_op_arbiter: round-robin arbiter sharing one fixed-latency two-operand SPU op unit
module elixirchip_es1_spu_op_arbiter #(
    parameter  int NUM_PORTS = 4,
    parameter  int DATA_BITS = 8,
    parameter  int LATENCY   = 1,
    localparam int ID_BITS   = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cke,
    input  logic [NUM_PORTS*DATA_BITS-1:0] s_data0,
    input  logic [NUM_PORTS*DATA_BITS-1:0] s_data1,
    input  logic [NUM_PORTS-1:0]           s_valid,
    output logic [NUM_PORTS-1:0]           s_ready,
    output logic [DATA_BITS-1:0]           op_data0,
    output logic [DATA_BITS-1:0]           op_data1,
    output logic                           op_valid,
    output logic                           op_clear,
    input  logic [DATA_BITS-1:0]           op_data,
    output logic [DATA_BITS-1:0]           m_data,
    output logic [ID_BITS-1:0]             m_id,
    output logic                           m_valid,
    output logic                           busy
);
    logic [ID_BITS-1:0] last_grant;
    logic [ID_BITS-1:0] grant_id;
    logic               grant_hit;
    logic               issue;
    logic [LATENCY-1:0] tag_valid;
    logic [ID_BITS-1:0] tag_id [LATENCY];

    // first valid requester found walking upward from the port after the last accepted one
    always_comb begin
        int idx;
        grant_hit = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (s_valid[idx]) begin
                grant_hit = 1'b1;
                grant_id  = ID_BITS'(idx);
            end
        end
    end

    assign issue    = grant_hit & cke & ~reset;
    assign s_ready  = issue ? NUM_PORTS'(1) << grant_id : '0;
    assign op_valid = issue;
    assign op_clear = ~issue;
    assign op_data0 = issue ? s_data0[grant_id*DATA_BITS +: DATA_BITS] : '0;
    assign op_data1 = issue ? s_data1[grant_id*DATA_BITS +: DATA_BITS] : '0;

    // grant pointer and issue tags move only on enabled cycles; reset drops every in-flight tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= ID_BITS'(NUM_PORTS - 1);
            tag_valid  <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
        end else if (cke) begin
            if (issue) last_grant <= grant_id;
            tag_valid[0] <= issue;
            tag_id[0]    <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign m_valid = tag_valid[LATENCY-1];
    assign m_id    = tag_id[LATENCY-1];
    assign m_data  = op_data;
    assign busy    = |tag_valid;
endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// tb_elixirchip_es1_spu_op_arbiter: randomized scoreboard bench with a 3-cycle NOR op unit
module tb_elixirchip_es1_spu_op_arbiter;
    localparam int NP = 4;
    localparam int DB = 8;
    localparam int LAT = 3;

    logic           clk;
    logic           reset;
    logic           cke;
    logic [NP*DB-1:0] s_data0;
    logic [NP*DB-1:0] s_data1;
    logic [NP-1:0]  s_valid;
    logic [NP-1:0]  s_ready;
    logic [DB-1:0]  op_data0;
    logic [DB-1:0]  op_data1;
    logic           op_valid;
    logic           op_clear;
    logic [DB-1:0]  op_data;
    logic [DB-1:0]  m_data;
    logic [1:0]     m_id;
    logic           m_valid;
    logic           busy;

    elixirchip_es1_spu_op_arbiter #(.NUM_PORTS(NP), .DATA_BITS(DB), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid), .s_ready(s_ready),
        .op_data0(op_data0), .op_data1(op_data1), .op_valid(op_valid), .op_clear(op_clear),
        .op_data(op_data), .m_data(m_data), .m_id(m_id), .m_valid(m_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // attached op unit: NOR with LAT enabled-cycle latency, cleared on idle slots
    logic [DB-1:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        if (cke) begin
            pipe[0] <= op_clear ? '0 : ~(op_data0 | op_data1);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign op_data = pipe[LAT-1];

    typedef struct {
        int         id;
        logic [7:0] res;
        int         due;
    } ent_t;

    ent_t q[$];
    int   lg;
    int   cnt;
    int   total;
    int   bad;
    int   wait0;
    int   max_wait0;

    // one clock: check outputs against the model, drive inputs, check grant, advance the model
    task automatic cycle(input logic c, input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1);
        logic       exp_mv;
        int         g;
        int         gi;
        logic [3:0] exp_ready;
        logic [7:0] a;
        logic [7:0] b;
        @(negedge clk);
        exp_mv = q.size() > 0 && q[0].due == cnt;
        total++;
        if (m_valid !== exp_mv) begin
            bad++;
            $display("FAIL m_valid got=%b want=%b t=%0t", m_valid, exp_mv, $time);
        end
        if (exp_mv) begin
            total++;
            if (m_id !== q[0].id[1:0] || m_data !== q[0].res) begin
                bad++;
                $display("FAIL result got id=%0d data=%h want id=%0d data=%h t=%0t", m_id, m_data, q[0].id, q[0].res, $time);
            end
        end
        total++;
        if (busy !== (q.size() != 0)) begin
            bad++;
            $display("FAIL busy got=%b want=%b t=%0t", busy, q.size() != 0, $time);
        end
        cke = c;
        s_valid = v;
        s_data0 = d0;
        s_data1 = d1;
        #1;
        g = -1;
        if (c) for (int k = 1; k <= NP; k++) if (g < 0 && v[(lg + k) % NP]) g = (lg + k) % NP;
        gi = g < 0 ? 0 : g;
        exp_ready = g >= 0 ? 4'(1 << g) : 4'b0;
        a = g >= 0 ? d0[gi*8 +: 8] : 8'h00;
        b = g >= 0 ? d1[gi*8 +: 8] : 8'h00;
        total++;
        if (s_ready !== exp_ready || op_valid !== (g >= 0) || op_clear !== (g < 0)) begin
            bad++;
            $display("FAIL grant got ready=%b valid=%b clear=%b want ready=%b t=%0t", s_ready, op_valid, op_clear, exp_ready, $time);
        end
        total++;
        if (op_data0 !== a || op_data1 !== b) begin
            bad++;
            $display("FAIL operands got %h/%h want %h/%h t=%0t", op_data0, op_data1, a, b, $time);
        end
        if (c) begin
            if (exp_mv) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{id: g, res: ~(a | b), due: cnt + LAT});
                if (v[0] && g != 0) wait0++;
                if (g == 0) wait0 = 0;
                if (wait0 > max_wait0) max_wait0 = wait0;
                lg = g;
            end
            cnt++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        cke = 1'b1;
        s_valid = 4'hF;
        #1;
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_id !== 2'd0 || s_ready !== 4'b0 || op_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got mv=%b busy=%b id=%0d ready=%b opv=%b want all 0", m_valid, busy, m_id, s_ready, op_valid);
        end
        @(negedge clk);
        s_valid = 4'h0;
        reset = 1'b0;
        q.delete();
        lg = NP - 1;
        wait0 = 0;
    endtask

    task automatic test_round_robin;
        test_reset;
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, i < 8 ? 4'hF : 4'h0, $urandom, $urandom);
            if (i < 8) begin
                total++;
                if (s_ready !== 4'(1 << (i % NP))) begin
                    bad++;
                    $display("FAIL rr_grant step %0d got=%b want=%b", i, s_ready, 4'(1 << (i % NP)));
                end
            end
            if (i >= LAT) begin
                total++;
                if (m_valid !== 1'b1 || m_id !== 2'((i - LAT) % NP)) begin
                    bad++;
                    $display("FAIL rr_mid step %0d got v=%b id=%0d want id=%0d", i, m_valid, m_id, (i - LAT) % NP);
                end
            end
        end
    endtask

    task automatic test_nor;
        test_reset;
        cycle(1'b1, 4'b0100, 32'h000F_0000, 32'h00F0_0000);
        for (int i = 0; i < LAT; i++) cycle(1'b1, 4'b0000, 32'h0, 32'h0);
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h00 || m_id !== 2'd2) begin
            bad++;
            $display("FAIL nor_result got v=%b data=%h id=%0d want v=1 data=00 id=2", m_valid, m_data, m_id);
        end
    endtask

    task automatic test_cke_freeze;
        logic       mv;
        logic [1:0] mi;
        logic       bz;
        test_reset;
        cycle(1'b1, 4'b1010, 32'h0000_3300, 32'h0000_0044);
        cycle(1'b1, 4'b1000, 32'h5500_0000, 32'h0600_0000);
        cycle(1'b1, 4'b0000, 32'h0, 32'h0);
        cycle(1'b0, 4'hF, $urandom, $urandom);
        mv = m_valid;
        mi = m_id;
        bz = busy;
        total++;
        if (mv !== 1'b1 || mi !== 2'd1 || bz !== 1'b1) begin
            bad++;
            $display("FAIL freeze_entry got v=%b id=%0d busy=%b want 1/1/1", mv, mi, bz);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'hF, $urandom, $urandom);
            total++;
            if (m_valid !== mv || m_id !== mi || busy !== bz) begin
                bad++;
                $display("FAIL freeze_hold got v=%b id=%0d busy=%b want %b/%0d/%b", m_valid, m_id, busy, mv, mi, bz);
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0000, 32'h0, 32'h0);
        cycle(1'b1, 4'hF, $urandom, $urandom);
        total++;
        if (s_ready !== 4'b0001) begin
            bad++;
            $display("FAIL freeze_next_grant got=%b want=0001", s_ready);
        end
    endtask

    task automatic test_reset_in_flight;
        test_reset;
        cycle(1'b1, 4'b0110, $urandom, $urandom);
        cycle(1'b1, 4'b0110, $urandom, $urandom);
        test_reset;
        for (int i = 0; i < LAT + 2; i++) begin
            cycle(1'b1, 4'b0000, 32'h0, 32'h0);
            total++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL flush got v=%b busy=%b want 0/0", m_valid, busy);
            end
        end
        cycle(1'b1, 4'hF, $urandom, $urandom);
        total++;
        if (s_ready !== 4'b0001) begin
            bad++;
            $display("FAIL flush_next_grant got=%b want=0001", s_ready);
        end
    endtask

    task automatic test_random;
        test_reset;
        max_wait0 = 0;
        for (int i = 0; i < 1000; i++)
            cycle(($urandom % 8) != 0, {3'($urandom), 1'b1}, $urandom, $urandom);
        for (int i = 0; i < LAT + 2; i++) cycle(1'b1, 4'b0000, 32'h0, 32'h0);
        total++;
        if (max_wait0 >= NP) begin
            bad++;
            $display("FAIL starvation got max_wait=%0d want <%0d", max_wait0, NP);
        end
        total++;
        if (q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain got pending=%0d busy=%b want 0/0", q.size(), busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        cke = 1'b0;
        s_valid = '0;
        s_data0 = '0;
        s_data1 = '0;
        lg = NP - 1;
        cnt = 0;
        total = 0;
        bad = 0;
        wait0 = 0;
        max_wait0 = 0;
        test_reset;
        test_round_robin;
        test_nor;
        test_cke_freeze;
        test_reset_in_flight;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
